// File: rtl/uart_tx_engine_p.sv
// UART transmit engine in the bit-clock domain: TX FIFO, runtime frame format,
// CTS gating and break generation. One clk_uart cycle is one bit time.
//
// state  | meaning
// IDLE   | line marking, waiting for a character or a break request
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even/odd parity bit
// STOP   | stop bit(s); also the single mark cycle that ends a break
// BREAK  | line held low while break_req is high
module uart_tx_engine_p #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_uart,
  input  logic              rst_n,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop,
  input  logic              cfg_cts_en,
  input  logic              cts_n,
  input  logic              break_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [AW:0]       fifo_level,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] head_masked;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shift;
  logic [3:0]        n_eff;
  logic [3:0]        n_len;
  logic [3:0]        bit_cnt;
  logic              par_en_eff;
  logic              par_bit_eff;
  logic              par_en;
  logic              par_bit;
  logic              two_stop;
  logic              stop_cnt;
  logic              brk_mark;
  logic              last_stop;
  logic              frame_edge;
  logic              start_ok;

  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == DEPTH_LVL);
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign tx_busy    = (state != IDLE);

  always_comb begin
    if (cfg_data_bits < 4'd5)
      n_eff = 4'd5;
    else if (cfg_data_bits > 4'(DATA_W))
      n_eff = 4'(DATA_W);
    else
      n_eff = cfg_data_bits;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++)
      mask[i] = (i < int'(n_eff));
  end

  assign head        = mem[rd_ptr];
  assign head_masked = head & mask;
  assign par_en_eff  = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
  assign par_bit_eff = (^head_masked) ^ (cfg_parity == 2'd2);

  // Frame boundaries are the only points where CTS, break and the FIFO are looked at.
  assign last_stop  = (state == STOP) && (brk_mark || (stop_cnt == two_stop));
  assign frame_edge = (state == IDLE) || (last_stop && !brk_mark);
  assign start_ok   = !fifo_empty && (!cfg_cts_en || !cts_n);
  assign pop        = frame_edge && !break_req && start_ok;

  always_ff @(posedge clk_uart) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // tx_out and tx_done are loaded with the value of the state being entered.
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
      shift    <= '0;
      n_len    <= 4'd5;
      bit_cnt  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
      stop_cnt <= 1'b0;
      brk_mark <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (break_req) begin
            state  <= BREAK;
            tx_out <= 1'b0;
          end else if (pop) begin
            state    <= START;
            tx_out   <= 1'b0;
            shift    <= head_masked;
            n_len    <= n_eff;
            par_en   <= par_en_eff;
            par_bit  <= par_bit_eff;
            two_stop <= cfg_stop;
          end
        end
        START: begin
          state   <= DATA;
          tx_out  <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == n_len - 4'd1) begin
            if (par_en) begin
              state  <= PARITY;
              tx_out <= par_bit;
            end else begin
              state    <= STOP;
              tx_out   <= 1'b1;
              stop_cnt <= 1'b0;
              tx_done  <= !two_stop;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx_out  <= shift[0];
            shift   <= shift >> 1;
          end
        end
        PARITY: begin
          state    <= STOP;
          tx_out   <= 1'b1;
          stop_cnt <= 1'b0;
          tx_done  <= !two_stop;
        end
        STOP: begin
          tx_out <= 1'b1;
          if (!last_stop) begin
            stop_cnt <= 1'b1;
            tx_done  <= 1'b1;
          end else if (brk_mark) begin
            state    <= IDLE;
            brk_mark <= 1'b0;
          end else if (break_req) begin
            state  <= BREAK;
            tx_out <= 1'b0;
          end else if (pop) begin
            state    <= START;
            tx_out   <= 1'b0;
            shift    <= head_masked;
            n_len    <= n_eff;
            par_en   <= par_en_eff;
            par_bit  <= par_bit_eff;
            two_stop <= cfg_stop;
          end else begin
            state <= IDLE;
          end
        end
        BREAK: begin
          if (break_req) begin
            tx_out <= 1'b0;
          end else begin
            state    <= STOP;
            tx_out   <= 1'b1;
            stop_cnt <= 1'b0;
            brk_mark <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine_p.sv
// Directed bench for uart_tx_engine_p: frame formats, FIFO full/CTS gating,
// back-to-back frames, break generation and mid-frame reset.
module tb_uart_tx_engine_p;

  logic       clk_uart;
  logic       rst_n;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_stop;
  logic       cfg_cts_en;
  logic       cts_n;
  logic       break_req;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [4:0] fifo_level;
  logic       fifo_empty;
  logic       fifo_full;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_engine_p dut (
    .clk_uart      (clk_uart),
    .rst_n         (rst_n),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop      (cfg_stop),
    .cfg_cts_en    (cfg_cts_en),
    .cts_n         (cts_n),
    .break_req     (break_req),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .fifo_level    (fifo_level),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .tx_out        (tx_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  initial begin
    clk_uart = 1'b0;
    forever #5 clk_uart = ~clk_uart;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_uart);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // bits[i] is the line level expected in the i-th frame cycle.
  task automatic expect_frame(input string tag, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      check_val($sformatf("%s_bit%0d", tag, i), tx_out, bits[i]);
      check_val($sformatf("%s_done%0d", tag, i), tx_done, (i == len - 1));
      check_val($sformatf("%s_busy%0d", tag, i), tx_busy, 1);
    end
  endtask

  initial begin
    logic [15:0] fr;
    rst_n         = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'd0;
    cfg_stop      = 1'b0;
    cfg_cts_en    = 1'b0;
    cts_n         = 1'b0;
    break_req     = 1'b0;
    wr_valid      = 1'b0;
    wr_data       = 8'h00;

    #23;
    check_val("rst_tx_out", tx_out, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_wr_ready", wr_ready, 1);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_empty", fifo_empty, 1);
    check_val("rst_full", fifo_full, 0);
    rst_n = 1'b1;
    tick();
    check_val("idle_tx_out", tx_out, 1);

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
    write_word(8'hA5);
    check_val("t1_level_after_wr", fifo_level, 1);
    check_val("t1_line_idle_at_wr", tx_out, 1);
    expect_frame("t1", 16'h034A, 10);
    tick();
    check_val("t1_idle_tx", tx_out, 1);
    check_val("t1_idle_busy", tx_busy, 0);
    check_val("t1_level_end", fifo_level, 0);

    // 7E2, 0x41: 0,1,0,0,0,0,0,1,0,1,1
    cfg_data_bits = 4'd7;
    cfg_parity    = 2'd1;
    cfg_stop      = 1'b1;
    write_word(8'h41);
    expect_frame("t2e", 16'h0682, 11);
    tick();
    check_val("t2e_idle", tx_busy, 0);

    // 7O2, 0x41: parity bit 1
    cfg_parity = 2'd2;
    write_word(8'h41);
    expect_frame("t2o", 16'h0782, 11);
    tick();
    check_val("t2o_idle", tx_busy, 0);

    // length 3 clamps to 5, upper bits of 0xFF dropped: 0,1,1,1,1,1,1
    cfg_data_bits = 4'd3;
    cfg_parity    = 2'd3;
    cfg_stop      = 1'b0;
    write_word(8'hFF);
    expect_frame("t_clamp5", 16'h007E, 7);
    tick();

    // length 15 clamps to 8
    cfg_data_bits = 4'd15;
    cfg_parity    = 2'd0;
    write_word(8'hA5);
    expect_frame("t_clamp8", 16'h034A, 10);
    tick();
    cfg_data_bits = 4'd8;

    // CTS held off: fill the FIFO, 17th write dropped
    cfg_cts_en = 1'b1;
    cts_n      = 1'b1;
    for (int i = 0; i < 17; i++)
      write_word(8'h30 + 8'(i));
    check_val("t3_level_full", fifo_level, 16);
    check_val("t3_full", fifo_full, 1);
    check_val("t3_wr_ready", wr_ready, 0);
    check_val("t3_empty", fifo_empty, 0);
    check_val("t3_tx_hold", tx_out, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t3_gated_tx", tx_out, 1);
      check_val("t3_gated_busy", tx_busy, 0);
    end
    cts_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fr = 16'h0000;
      fr[9] = 1'b1;
      fr[8:1] = 8'h30 + 8'(i);
      expect_frame($sformatf("t3_f%0d", i), fr, 10);
    end
    check_val("t3_level_drained", fifo_level, 0);
    tick();
    check_val("t3_idle_busy", tx_busy, 0);
    check_val("t3_idle_tx", tx_out, 1);
    check_val("t3_wr_ready_back", wr_ready, 1);

    // two queued words, back to back
    cts_n = 1'b1;
    write_word(8'h00);
    write_word(8'hFF);
    check_val("t4_level", fifo_level, 2);
    cts_n = 1'b0;
    expect_frame("t4_a", 16'h0200, 10);
    expect_frame("t4_b", 16'h03FE, 10);
    tick();
    check_val("t4_idle", tx_busy, 0);
    cfg_cts_en = 1'b0;

    // break raised mid-frame
    write_word(8'hA5);
    fr = 16'h034A;
    for (int t = 0; t < 26; t++) begin
      tick();
      if (t <= 9)
        check_val($sformatf("t5_tx%0d", t), tx_out, fr[t]);
      else if (t <= 22)
        check_val($sformatf("t5_tx%0d", t), tx_out, 0);
      else
        check_val($sformatf("t5_tx%0d", t), tx_out, 1);
      check_val($sformatf("t5_done%0d", t), tx_done, (t == 9));
      check_val($sformatf("t5_busy%0d", t), tx_busy, (t <= 23));
      if (t == 2)
        break_req = 1'b1;
      if (t == 22)
        break_req = 1'b0;
    end

    // reset during data bit 3
    write_word(8'h00);
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    tick();
    wr_valid = 1'b0;
    check_val("t6_start", tx_out, 0);
    check_val("t6_level", fifo_level, 1);
    for (int i = 0; i < 4; i++)
      tick();
    check_val("t6_bit3_low", tx_out, 0);
    check_val("t6_bit3_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_tx", tx_out, 1);
    check_val("t6_rst_level", fifo_level, 0);
    check_val("t6_rst_busy", tx_busy, 0);
    check_val("t6_rst_empty", fifo_empty, 1);
    #2 rst_n = 1'b1;
    tick();
    check_val("t6_post_tx", tx_out, 1);
    check_val("t6_post_busy", tx_busy, 0);
    write_word(8'hA5);
    expect_frame("t6_fresh", 16'h034A, 10);
    tick();
    check_val("t6_final_idle", tx_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
